// File: rtl/instr_fetch.sv
// instr_fetch: RAM port-0 fetch stage with valid/ready output; skid buffer enabled by IFETCH_SKID_EN
module instr_fetch #(
    parameter int                ADDR_W   = 7,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 7'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              ram_read_en,
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, fly_pc, skid_pc;
    logic [DATA_W-1:0] skid_data;
    logic              fly, skid_valid, issue, issue_ok, flush, land, out_free;

    assign flush        = redirect_valid && state != IDLE;
    assign land         = fly && !flush;
    assign out_free     = !instr_valid || instr_ready;
    assign ram_write_en = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (start && !halt) ? RUN : IDLE;
            RUN:     state_nxt = halt ? DRAIN : RUN;
            DRAIN:   state_nxt = (!fly && !instr_valid && !skid_valid) ? IDLE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        issue       = state == RUN && !redirect_valid && !skid_valid && out_free && issue_ok;
        ram_read_en = issue;
        ram_addr    = pc;
        busy        = state != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            fly    <= 1'b0;
            fly_pc <= '0;
        end else begin
            pc     <= redirect_valid ? redirect_pc : issue ? pc + ADDR_W'(1) : pc;
            fly    <= issue;
            fly_pc <= pc;
        end
    end

    // skid content always precedes the landing word, keeping delivery in order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else if (flush) begin
            instr_valid <= 1'b0;
        end else if (out_free) begin
            instr_valid <= skid_valid || land;
            if (skid_valid || land) begin
                instr    <= skid_valid ? skid_data : ram_dout;
                instr_pc <= skid_valid ? skid_pc : fly_pc;
            end
        end
    end

`ifdef IFETCH_SKID_EN
    assign issue_ok = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_pc    <= '0;
        end else if (flush) begin
            skid_valid <= 1'b0;
        end else if (land && (skid_valid || !out_free)) begin
            skid_valid <= 1'b1;
            skid_data  <= ram_dout;
            skid_pc    <= fly_pc;
        end else if (out_free) begin
            skid_valid <= 1'b0;
        end
    end
`else
    // one read at a time guarantees the landing word always finds the output free
    assign issue_ok   = !fly;
    assign skid_valid = 1'b0;
    assign skid_data  = '0;
    assign skid_pc    = '0;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed stimulus with a delivery-order scoreboard and RAM model
module tb_instr_fetch;
`ifdef IFETCH_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start = 1'b0, halt = 1'b0, redirect_valid = 1'b0, instr_ready = 1'b1;
    logic [6:0]  redirect_pc = '0;
    logic        ram_read_en, ram_write_en, instr_valid, busy;
    logic [6:0]  ram_addr, instr_pc;
    logic [15:0] ram_dout = '0, instr;
    logic [15:0] mem [128];
    int          vectors = 0, miscompares = 0;
    logic [6:0]  del_pc [$];
    logic [15:0] del_dat [$];
    logic [6:0]  exp_pc, exp_iss, held_pc;
    logic [15:0] held_instr;
    logic        stall_prev, prev_iss, m_run;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ram_read_en(ram_read_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
        .ram_dout(ram_dout), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_read_en) ram_dout <= mem[ram_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected delivery stream: consecutive PCs restarting at every redirect, data = mem[pc]
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc = 7'd0; exp_iss = 7'd0; stall_prev = 0; prev_iss = 0; m_run = 0;
        end else begin
            chk("write_en", ram_write_en, 0);
            if (stall_prev) begin
                chk("stall_valid", instr_valid, 1);
                chk("stall_instr", instr, held_instr);
                chk("stall_pc", instr_pc, held_pc);
            end
            if (redirect_valid) begin
                chk("redirect_no_issue", ram_read_en, 0);
                exp_pc = redirect_pc; exp_iss = redirect_pc;
            end else begin
                if (ram_read_en) begin
                    chk("issue_addr", ram_addr, exp_iss);
                    chk("issue_running", m_run, 1);
                    chk("issue_unstalled", instr_valid && !instr_ready, 0);
                    if (!SKID) chk("issue_single_flight", prev_iss, 0);
                    exp_iss = exp_iss + 7'd1;
                end
                if (instr_valid && instr_ready) begin
                    chk("xfer_pc", instr_pc, exp_pc);
                    chk("xfer_data", instr, mem[exp_pc]);
                    del_pc.push_back(instr_pc);
                    del_dat.push_back(instr);
                    exp_pc = exp_pc + 7'd1;
                end
            end
            stall_prev = instr_valid && !instr_ready && !redirect_valid;
            held_instr = instr; held_pc = instr_pc; prev_iss = ram_read_en;
            if (start && !halt && !busy) m_run = 1;
            if (halt) m_run = 0;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_del(input int n, input string name);
        for (int i = 0; i < 60 && del_pc.size() < n; i++) tick();
        chk(name, del_pc.size() >= n, 1);
    endtask

    task automatic drain(input string name);
        halt = 1; tick(); halt = 0;
        for (int i = 0; i < 40 && busy; i++) tick();
        chk(name, busy, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk({name, "_quiet"}, ram_read_en, 0);
        end
        tick();
    endtask

    task automatic clear_q();
        del_pc.delete(); del_dat.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = (i < 4) ? 16'h1000 + 16'(i) : 16'($urandom);
        @(negedge clk);
        chk("rst_valid", instr_valid, 0); chk("rst_read_en", ram_read_en, 0);
        chk("rst_busy", busy, 0);         chk("rst_addr", ram_addr, 0);
        chk("rst_instr", instr, 0);       chk("rst_instr_pc", instr_pc, 0);
        tick(); rst_n = 1;

        // basic stream and latency
        start = 1; tick(); start = 0;
        @(negedge clk); chk("first_issue", ram_read_en, 1); chk("first_addr", ram_addr, 0);
        tick(); @(negedge clk); chk("lat_not_yet", instr_valid, 0);
        tick(); @(negedge clk); chk("lat_valid", instr_valid, 1);
        chk("lat_pc", instr_pc, 0); chk("lat_instr", instr, 16'h1000);
        tick(); @(negedge clk);
        if (SKID) chk("tput_pc1", instr_pc, 1);
        else      chk("tput_gap", instr_valid, 0);
        repeat (3) tick();
        // back-pressure
        instr_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); @(negedge clk); chk("stalled_valid", instr_valid, 1);
        end
        tick(); instr_ready = 1;
        repeat (4) tick();
        drain("drain1");
        chk("seq_pc0", del_pc[0], 0); chk("seq_pc3", del_pc[3], 3);
        chk("seq_d1", del_dat[1], 16'h1001); chk("seq_d3", del_dat[3], 16'h1003);

        // redirect flushes output (PC 4) and in-flight read (PC 5)
        clear_q();
        redirect_valid = 1; redirect_pc = 7'd4; tick(); redirect_valid = 0;
        instr_ready = 0; start = 1; tick(); start = 0;
        tick(); tick();
        redirect_valid = 1; redirect_pc = 7'd40;
        @(negedge clk); chk("pre_redir_valid", instr_valid, 1); chk("pre_redir_pc", instr_pc, 4);
        tick(); redirect_valid = 0; instr_ready = 1;
        @(negedge clk); chk("post_redir_issue", ram_read_en, 1); chk("post_redir_addr", ram_addr, 40);
        tick(); @(negedge clk); chk("post_redir_gap", instr_valid, 0);
        tick(); @(negedge clk); chk("post_redir_valid", instr_valid, 1); chk("post_redir_pc", instr_pc, 40);
        wait_del(1, "redir_del");
        drain("drain2");
        chk("redir_first", del_pc[0], 40);

        // PC wrap from 126
        clear_q();
        redirect_valid = 1; redirect_pc = 7'd126; tick(); redirect_valid = 0;
        start = 1; tick(); start = 0;
        wait_del(4, "wrap_del");
        drain("drain3");
        chk("wrap0", del_pc[0], 126); chk("wrap1", del_pc[1], 127);
        chk("wrap2", del_pc[2], 0);   chk("wrap3", del_pc[3], 1);

        // halt with output (and skid) full
        clear_q();
        redirect_valid = 1; redirect_pc = 7'd10; tick(); redirect_valid = 0;
        instr_ready = 0; start = 1; tick(); start = 0;
        tick(); tick(); tick();
        @(negedge clk); chk("full_no_issue", ram_read_en, 0);
        chk("full_valid", instr_valid, 1); chk("full_pc", instr_pc, 10); chk("full_busy", busy, 1);
        tick(); halt = 1; tick(); halt = 0; instr_ready = 1;
        for (int i = 0; i < 40 && busy; i++) tick();
        chk("halt_idle", busy, 0);
        chk("halt_count", del_pc.size(), SKID ? 2 : 1);
        chk("halt_pc0", del_pc[0], 10);
        if (SKID) chk("halt_pc1", del_pc[1], 11);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("halt_quiet", ram_read_en, 0);
        end

        // asynchronous reset mid-stream
        tick(); start = 1; tick(); start = 0;
        repeat (5) tick();
        #1 rst_n = 0;
        #1 chk("arst_valid", instr_valid, 0); chk("arst_read_en", ram_read_en, 0); chk("arst_busy", busy, 0);
        tick(); tick(); rst_n = 1; clear_q();
        start = 1; tick(); start = 0;
        wait_del(1, "arst_del");
        chk("arst_pc", del_pc[0], 0); chk("arst_data", del_dat[0], 16'h1000);
        drain("drain4");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
